// File: rtl/tinysat_multi.sv
// rtl/tinysat_multi.sv - brute-force SAT engine: clause store, assignment sweep, solution handshake
// Optional feature macro SAT_ENUM_EN: enumerate every solution instead of stopping at the first.
module tinysat_multi #(
   parameter  int NVARS        = 8,
   parameter  int LOG2_CLAUSES = 5,
   parameter  int LITS         = 3,
   localparam int LIT_W        = $clog2(NVARS+1)+1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [LIT_W-1:0] load_lit,
   output logic             load_ready,
   input  logic             start,
   output logic             busy,
   output logic             sol_valid,
   output logic [NVARS-1:0] sol_x,
   input  logic             sol_ack,
   output logic             done,
   output logic             sat,
   output logic [NVARS:0]   sol_count
);

   localparam int IDX_W  = LIT_W-1;
   localparam int NCL    = 2**LOG2_CLAUSES;
   localparam int SLOT_W = (LITS > 1) ? $clog2(LITS) : 1;
   localparam logic [NVARS-1:0]  X_MAX     = '1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LITS-1);

   typedef enum logic [1:0] {IDLE, EVAL, REPORT, DONE} state_t;
   state_t state, state_nx;

   logic [LITS-1:0][LIT_W-1:0] clause_mem [NCL];
   logic [LOG2_CLAUSES-1:0]    wr_c, last_c, c;
   logic [SLOT_W-1:0]          wr_s;
   logic                       any_c;
   logic [NVARS-1:0]           x;
   logic                       wr_en;
   logic                       clause_true;
   logic                       clause_hit;

   assign load_ready = (state == IDLE);
   assign busy       = (state == EVAL) || (state == REPORT);
   assign sol_valid  = (state == REPORT);
   assign done       = (state == DONE);
   assign wr_en      = load_valid && load_ready;

   // Write pointer kept as {clause, slot}; clause wraps naturally at NCL.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_c   <= '0;
         wr_s   <= '0;
         last_c <= '0;
         any_c  <= 1'b0;
      end else if (wr_en) begin
         if (wr_s == SLOT_LAST) begin
            wr_s <= '0;
            wr_c <= wr_c + 1'b1;
         end else begin
            wr_s <= wr_s + 1'b1;
         end
         if (!any_c || (wr_c > last_c))
            last_c <= wr_c;
         any_c <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         clause_mem[wr_c][wr_s] <= load_lit;
   end

   // Index 0 and indices beyond NVARS never match, so they read as false.
   function automatic logic lit_true(input logic [LIT_W-1:0] lit, input logic [NVARS-1:0] xv);
      logic v;
      v = 1'b0;
      for (int i = 0; i < NVARS; i++)
         if (lit[IDX_W-1:0] == IDX_W'(i+1))
            v = xv[i] ^ lit[LIT_W-1];
      return v;
   endfunction

   always_comb begin
      clause_true = 1'b0;
      for (int s = 0; s < LITS; s++)
         clause_true = clause_true | lit_true(clause_mem[c][s], x);
   end

   // An empty formula is satisfied by every assignment.
   assign clause_hit = !any_c || (clause_true && (c == last_c));

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start)
               state_nx = EVAL;
         end
         EVAL: begin
            if (clause_hit)
               state_nx = REPORT;
            else if (!clause_true && (x == X_MAX))
               state_nx = DONE;
         end
         REPORT: begin
            if (sol_ack) begin
`ifdef SAT_ENUM_EN
               state_nx = (x == X_MAX) ? DONE : EVAL;
`else
               state_nx = DONE;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x         <= '0;
         c         <= '0;
         sol_x     <= '0;
         sat       <= 1'b0;
         sol_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  x         <= '0;
                  c         <= '0;
                  sat       <= 1'b0;
                  sol_count <= '0;
               end
            end
            EVAL: begin
               if (clause_hit) begin
                  sol_x <= x;
                  sat   <= 1'b1;
               end else if (clause_true) begin
                  c <= c + 1'b1;
               end else if (x != X_MAX) begin
                  x <= x + 1'b1;
                  c <= '0;
               end
            end
            REPORT: begin
               if (sol_ack) begin
                  if (sol_count != '1)
                     sol_count <= sol_count + 1'b1;
`ifdef SAT_ENUM_EN
                  if (x != X_MAX) begin
                     x <= x + 1'b1;
                     c <= '0;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tinysat_multi.sv
// tb/tb_tinysat_multi.sv - directed table-driven bench for tinysat_multi (NVARS=3, 4 clauses x 3 literals)
module tb_tinysat_multi;

   logic       clk;
   logic       reset;
   logic       load_valid;
   logic [2:0] load_lit;
   logic       load_ready;
   logic       start;
   logic       busy;
   logic       sol_valid;
   logic [2:0] sol_x;
   logic       sol_ack;
   logic       done;
   logic       sat;
   logic [3:0] sol_count;

   int n_checks = 0;
   int n_fail   = 0;

   tinysat_multi #(.NVARS(3), .LOG2_CLAUSES(2), .LITS(3)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_lit(load_lit),
      .load_ready(load_ready), .start(start), .busy(busy), .sol_valid(sol_valid),
      .sol_x(sol_x), .sol_ack(sol_ack), .done(done), .sat(sat), .sol_count(sol_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] l0, l1, l2;
      logic [7:0] mask;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".reset_outs"},
            32'({load_ready, busy, sol_valid, sol_x, done, sat, sol_count}), 32'h800);
   endtask

   task automatic load(input logic [2:0] lit);
      load_valid = 1'b1;
      load_lit   = lit;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic drain(input int budget, output logic [7:0] mask, output logic [2:0] first,
                        output int nsol, output bit timeout);
      mask = '0; first = '0; nsol = 0; timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            timeout = 1'b0;
            break;
         end
         if (sol_valid) begin
            if (nsol == 0) first = sol_x;
            mask[sol_x] = 1'b1;
            nsol++;
            sol_ack = 1'b1;
         end
         @(negedge clk);
         sol_ack = 1'b0;
         start   = 1'b0;
      end
   endtask

   task automatic sweep(output logic [7:0] mask, output logic [2:0] first,
                        output int nsol, output bit timeout);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain(200, mask, first, nsol, timeout);
   endtask

   task automatic check_sweep(input string tag, input logic [7:0] exp_mask, input logic [7:0] mask,
                              input logic [2:0] first, input int nsol, input bit timeout);
      int pop, lo;
      pop = 0; lo = 0;
      for (int i = 7; i >= 0; i--)
         if (exp_mask[i]) begin
            pop++;
            lo = i;
         end
      check({tag, ".timeout"}, 32'(timeout), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".sat"}, 32'(sat), 32'(exp_mask != 8'h00));
      if (pop != 0) check({tag, ".first"}, 32'(first), 32'(lo));
`ifdef SAT_ENUM_EN
      check({tag, ".mask"}, 32'(mask), 32'(exp_mask));
      check({tag, ".nsol"}, 32'(nsol), 32'(pop));
      check({tag, ".count"}, 32'(sol_count), 32'(pop));
`else
      check({tag, ".mask_subset"}, 32'(mask & ~exp_mask), 32'd0);
      check({tag, ".nsol"}, 32'(nsol), 32'(pop != 0));
      check({tag, ".count"}, 32'(sol_count), 32'(pop != 0));
`endif
   endtask

   logic [7:0] mask;
   logic [2:0] first;
   int         nsol;
   bit         tmo;
   bit         seen_valid;

   initial begin
      // literal = {neg, idx}: +k = k, -k = 4+k, 0 = empty
      vecs[0] = '{3'd1, 3'd0, 3'd0, 8'hAA};  // x1
      vecs[1] = '{3'd5, 3'd0, 3'd0, 8'h55};  // ~x1
      vecs[2] = '{3'd3, 3'd0, 3'd0, 8'hF0};  // x3
      vecs[3] = '{3'd6, 3'd7, 3'd0, 8'h3F};  // ~x2 | ~x3
      vecs[4] = '{3'd0, 3'd0, 3'd0, 8'h00};  // all empty
      vecs[5] = '{3'd2, 3'd3, 3'd0, 8'hFC};  // x2 | x3
      vecs[6] = '{3'd4, 3'd4, 3'd4, 8'h00};  // negated empty slots
      vecs[7] = '{3'd1, 3'd2, 3'd3, 8'hFE};  // x1 | x2 | x3
      vecs[8] = '{3'd5, 3'd2, 3'd0, 8'hDD};  // ~x1 | x2

      reset = 1'b1; load_valid = 1'b0; load_lit = '0; start = 1'b0; sol_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_reset("init");

      // Empty formula: solution two cycles after start.
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("empty.n0_valid", 32'(sol_valid), 32'd0);
      check("empty.n0_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("empty.n1_valid", 32'(sol_valid), 32'd1);
      check("empty.n1_x", 32'(sol_x), 32'd0);
      drain(200, mask, first, nsol, tmo);
      check_sweep("empty", 8'hFF, mask, first, nsol, tmo);

      for (int v = 0; v < 9; v++) begin
         do_reset();
         load(vecs[v].l0);
         load(vecs[v].l1);
         load(vecs[v].l2);
         sweep(mask, first, nsol, tmo);
         check_sweep($sformatf("vec%0d", v), vecs[v].mask, mask, first, nsol, tmo);
      end

      // {x1},{~x1}: unsatisfiable, 12 evaluation cycles.
      do_reset();
      load(3'd1); load(3'd0); load(3'd0);
      load(3'd5); load(3'd0); load(3'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_valid = sol_valid;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | sol_valid;
      end
      check("unsat.n11_done", 32'(done), 32'd0);
      check("unsat.n11_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("unsat.n12_done", 32'(done), 32'd1);
      check("unsat.never_valid", 32'(seen_valid | sol_valid), 32'd0);
      check("unsat.sat", 32'(sat), 32'd0);
      check("unsat.count", 32'(sol_count), 32'd0);

      // Solution held while ack stays low; start ignored in REPORT.
      do_reset();
      load(3'd1); load(3'd0); load(3'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("hold.n1_valid", 32'(sol_valid), 32'd0);
      @(negedge clk);
      check("hold.n2_valid", 32'(sol_valid), 32'd1);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold.valid%0d", i), 32'(sol_valid), 32'd1);
         check($sformatf("hold.x%0d", i), 32'(sol_x), 32'd1);
         check($sformatf("hold.busy%0d", i), 32'(busy), 32'd1);
         check($sformatf("hold.ready%0d", i), 32'(load_ready), 32'd0);
      end
      start = 1'b0;
      drain(200, mask, first, nsol, tmo);
      check_sweep("hold", 8'hAA, mask, first, nsol, tmo);

      // 13 literals into 12 slots: last write turns clause 0 from ~x1 into x1.
      do_reset();
      load(3'd5); load(3'd0); load(3'd0);
      for (int i = 0; i < 3; i++) begin
         load(3'd3); load(3'd0); load(3'd0);
      end
      load(3'd1);
      sweep(mask, first, nsol, tmo);
      check_sweep("wrap", 8'hA0, mask, first, nsol, tmo);

      // Reset mid-EVAL, then behaves as an empty formula.
      do_reset();
      load(3'd1); load(3'd0); load(3'd0);
      load(3'd5); load(3'd0); load(3'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      do_reset();
      check_reset("midreset");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midreset.n0_valid", 32'(sol_valid), 32'd0);
      @(negedge clk);
      check("midreset.n1_valid", 32'(sol_valid), 32'd1);
      check("midreset.n1_x", 32'(sol_x), 32'd0);
      drain(200, mask, first, nsol, tmo);
      check_sweep("midreset", 8'hFF, mask, first, nsol, tmo);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
